data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Round-robin arbiter that shares the single data_mem port between NUM_PORTS load/store requesters, e.g. several load/store reservation stations.
- Forwards one request per accepted handshake to data_mem.
- Records the issuing port of every read in an in-order tag FIFO, and routes each data_mem result back to the port that issued it.
- Sits between the load/store reservation stations and data_mem.

Parameters:
NUM_PORTS, 2, number of requesters (2..8)
RS_ID_WIDTH, 5, width of rs_id fields, matches data_mem
MAX_OUTSTANDING, 4, tag FIFO depth = max reads in flight (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  [0:NUM_PORTS-1]  per-port request valid
req_ready  out  [0:NUM_PORTS-1]  per-port request accepted
req_rs_id  in  [0:NUM_PORTS-1][0:RS_ID_WIDTH-1]  per-port rs id
req_result_reg_addr  in  [0:NUM_PORTS-1][0:4]  per-port destination GPR
req_address  in  [0:NUM_PORTS-1][0:31]  per-port byte address
req_write_en  in  [0:NUM_PORTS-1][0:3]  per-port byte write enables
req_write_data  in  [0:NUM_PORTS-1][0:31]  per-port store data
req_read_en  in  [0:NUM_PORTS-1][0:3]  per-port byte read enables
mem_valid  out  1  to data_mem input_valid
mem_ready  in  1  from data_mem input_ready
mem_rs_id, mem_result_reg_addr, mem_address, mem_write_en, mem_write_data, mem_read_en  out  RS_ID_WIDTH/5/32/4/32/4  muxed request fields to data_mem
mem_out_valid  in  1  data_mem output_valid
mem_out_ready  out  1  to data_mem output_ready
mem_out_rs_id, mem_out_result_reg_addr, mem_out_read_data  in  RS_ID_WIDTH/5/32  data_mem results
resp_valid  out  [0:NUM_PORTS-1]  one-hot result valid toward the owning port
resp_ready  in  [0:NUM_PORTS-1]  per-port result ready
resp_rs_id, resp_result_reg_addr, resp_read_data  out  RS_ID_WIDTH/5/32  broadcast result fields
err_unexpected_resp  out  1  sticky: mem_out_valid seen while tag FIFO empty

Behaviour:
- Reset: req_ready=0, mem_valid=0, resp_valid=0, mem_out_ready=0, err_unexpected_resp=0, rr pointer=0, lock cleared, FIFO empty (count=0).
- Eligible port i:
  - req_valid[i]=1, and
  - it is not a read, or FIFO count<MAX_OUTSTANDING.
  - A read is any request with read_en!=0 and write_en==0.
- Grant:
  - With no lock, pick the first eligible port scanning from the rr pointer upward with wrap.
  - mem_valid=1 and all mem_* fields come combinationally from the granted port.
  - If mem_ready=0, set the lock to the granted port. The lock holds the grant stable, so fields stay stable until accepted.
  - Eligibility is not re-evaluated while locked.
- Accept:
  - req_ready[g] = mem_valid & mem_ready for granted port g; all other ports 0.
  - On accept: rr pointer <= g+1 mod NUM_PORTS, lock cleared.
  - If the request is a read, push g into the tag FIFO in the same cycle.
- Null request (write_en==0 and read_en==0):
  - data_mem never accepts it, so it is not forwarded (mem_valid=0 for it).
  - The arbiter accepts it locally: req_ready[g]=1 the same cycle it is granted.
  - The rr pointer advances; no FIFO push.
- Stores produce no data_mem output and are never tagged. Misaligned stores and reads that occupy data_mem for 2 cycles are covered by mem_ready backpressure.
- Response path:
  - head = FIFO head port.
  - resp_valid[head] = mem_out_valid & (count>0); other bits 0.
  - mem_out_ready = (count>0) & resp_ready[head].
  - resp_* fields are mem_out_* passed through, with 0 latency.
  - Pop on mem_out_valid & mem_out_ready.
- Simultaneous push and pop: count is unchanged. Push is allowed when count==MAX_OUTSTANDING only if a pop occurs the same cycle. That case is not used for eligibility; eligibility stays conservative.
- If mem_out_valid=1 while count=0: mem_out_ready=0, err_unexpected_resp <= 1 (sticky until rst).
- Reset mid-operation clears the lock and the FIFO. The upstream and data_mem resets are asserted together.
- Request latency: arbiter adds 0 cycles. Throughput: 1 grant per cycle when mem_ready=1.

Test Plan:
1. Both ports issue continuous aligned reads (addr 0x100 / 0x200), mem_ready=1 -> grants alternate 0,1,0,1. Each resp_valid one-hot matches the issuing port, in order.
2. Port 1 issues a misaligned store (addr 0x3, write_en 1111) while port 0 waits, mem_ready low for 1 cycle -> mem_* held from port 1 for 2 cycles, req_ready[1] pulses once, then port 0 granted. No FIFO push.
3. Five back-to-back reads from port 0 with resp_ready[0]=0, MAX_OUTSTANDING=4 -> 4 accepted, 5th held (req_ready=0). Releasing resp_ready pops one and the 5th is accepted the next cycle.
4. Port 0 issues a null request (both enables 0) -> req_ready[0]=1 in the grant cycle, mem_valid=0, rr pointer advances to 1.
5. Inject mem_out_valid=1 with FIFO empty -> mem_out_ready=0, err_unexpected_resp=1 next cycle and stays 1 until rst.
6. Assert rst with 2 reads outstanding and the lock held -> next cycle all outputs at reset values, count=0, and the first new grant goes to port 0.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one data_mem port between NUM_PORTS load/store
// requesters. Read issuers are remembered in an in-order tag FIFO so each
// data_mem result is steered back to the port that asked for it.
module data_mem_arbiter #(
   parameter int NUM_PORTS       = 2,
   parameter int RS_ID_WIDTH     = 5,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [0:NUM_PORTS-1]                  req_valid,
   output logic [0:NUM_PORTS-1]                  req_ready,
   input  logic [0:NUM_PORTS-1][0:RS_ID_WIDTH-1] req_rs_id,
   input  logic [0:NUM_PORTS-1][0:4]             req_result_reg_addr,
   input  logic [0:NUM_PORTS-1][0:31]            req_address,
   input  logic [0:NUM_PORTS-1][0:3]             req_write_en,
   input  logic [0:NUM_PORTS-1][0:31]            req_write_data,
   input  logic [0:NUM_PORTS-1][0:3]             req_read_en,
   output logic                                  mem_valid,
   input  logic                                  mem_ready,
   output logic [0:RS_ID_WIDTH-1]                mem_rs_id,
   output logic [0:4]                            mem_result_reg_addr,
   output logic [0:31]                           mem_address,
   output logic [0:3]                            mem_write_en,
   output logic [0:31]                           mem_write_data,
   output logic [0:3]                            mem_read_en,
   input  logic                                  mem_out_valid,
   output logic                                  mem_out_ready,
   input  logic [0:RS_ID_WIDTH-1]                mem_out_rs_id,
   input  logic [0:4]                            mem_out_result_reg_addr,
   input  logic [0:31]                           mem_out_read_data,
   output logic [0:NUM_PORTS-1]                  resp_valid,
   input  logic [0:NUM_PORTS-1]                  resp_ready,
   output logic [0:RS_ID_WIDTH-1]                resp_rs_id,
   output logic [0:4]                            resp_result_reg_addr,
   output logic [0:31]                           resp_read_data,
   output logic                                  err_unexpected_resp
);

   localparam int PW = $clog2(NUM_PORTS);
   localparam int AW = $clog2(MAX_OUTSTANDING);
   localparam int CW = AW + 1;

   typedef logic [PW-1:0] port_t;

   // Arbitration state
   port_t          rr_ptr;
   logic           lock_valid;
   port_t          lock_port;

   // Tag FIFO state
   port_t          tag_mem [MAX_OUTSTANDING];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [CW-1:0]  count;
   logic           err_q;

   logic [0:NUM_PORTS-1] is_read;
   logic [0:NUM_PORTS-1] is_null;
   logic [0:NUM_PORTS-1] eligible;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 scan_found;
   port_t                scan_port;
   logic                 grant_valid;
   port_t                grant_port;
   logic                 accept;
   logic                 push;
   logic                 pop;
   port_t                head_port;

   assign fifo_full  = (count == CW'(MAX_OUTSTANDING));
   assign fifo_empty = (count == '0);

   // Classify each request and decide whether it may compete this cycle
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         is_read[i]  = (req_read_en[i] != '0) && (req_write_en[i] == '0);
         is_null[i]  = (req_read_en[i] == '0) && (req_write_en[i] == '0);
         // Reads need a free tag slot; a same-cycle pop is deliberately ignored.
         eligible[i] = req_valid[i] && (!is_read[i] || !fifo_full);
      end
   end

   // First eligible port at or after the round-robin pointer, with wrap
   always_comb begin
      int idx;
      // NOTE: every variable gets a default before any conditional write,
      // otherwise the block infers a latch.
      idx        = 0;
      scan_found = 1'b0;
      scan_port  = rr_ptr;
      for (int k = 0; k < NUM_PORTS; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
         if (!scan_found && eligible[idx]) begin
            scan_found = 1'b1;
            scan_port  = port_t'(idx);
         end
      end
   end

   // A held lock overrides the scan so a stalled request stays stable
   always_comb begin
      grant_valid = lock_valid || scan_found;
      grant_port  = lock_valid ? lock_port : scan_port;
      // Null requests are absorbed here because data_mem would never take them.
      mem_valid   = !rst && grant_valid && !is_null[grant_port];
      accept      = !rst && grant_valid && (is_null[grant_port] || mem_ready);
      push        = accept && is_read[grant_port];
      req_ready   = '0;
      if (accept) req_ready[grant_port] = 1'b1;
   end

   assign mem_rs_id           = req_rs_id[grant_port];
   assign mem_result_reg_addr = req_result_reg_addr[grant_port];
   assign mem_address         = req_address[grant_port];
   assign mem_write_en        = req_write_en[grant_port];
   assign mem_write_data      = req_write_data[grant_port];
   assign mem_read_en         = req_read_en[grant_port];

   // Steer the data_mem result to the port at the head of the tag FIFO
   always_comb begin
      head_port     = tag_mem[rd_ptr];
      mem_out_ready = !rst && !fifo_empty && resp_ready[head_port];
      pop           = mem_out_valid && mem_out_ready;
      resp_valid    = '0;
      if (!rst && mem_out_valid && !fifo_empty) resp_valid[head_port] = 1'b1;
   end

   assign resp_rs_id           = mem_out_rs_id;
   assign resp_result_reg_addr = mem_out_result_reg_addr;
   assign resp_read_data       = mem_out_read_data;
   assign err_unexpected_resp  = err_q;

   // Round-robin pointer, grant lock, FIFO pointers/count and error flag
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         rr_ptr     <= '0;
         lock_valid <= 1'b0;
         lock_port  <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         err_q      <= 1'b0;
      end else begin
         if (accept) begin
            rr_ptr     <= (grant_port == port_t'(NUM_PORTS - 1)) ? '0 : port_t'(grant_port + 1'b1);
            lock_valid <= 1'b0;
         end else if (mem_valid) begin
            lock_valid <= 1'b1;
            lock_port  <= grant_port;
         end
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (mem_out_valid && fifo_empty) err_q <= 1'b1;
      end
   end

   // Tag storage: issuing port of every accepted read
   always_ff @(posedge clk) begin
      // NOTE: the tag array is not reset; count gates every read of it, so
      // stale entries are never observed.
      if (push) tag_mem[wr_ptr] <= grant_port;
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter (NUM_PORTS=2, MAX_OUTSTANDING=4).
// A vector table covers the cycle-by-cycle arbitration cases; hand-written
// sequences cover FIFO-full stall, unexpected response and mid-flight reset.
module tb_data_mem_arbiter;

   localparam int NP = 2;
   localparam int RW = 5;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [0:NP-1]             req_valid;
   logic [0:NP-1]             req_ready;
   logic [0:NP-1][0:RW-1]     req_rs_id;
   logic [0:NP-1][0:4]        req_result_reg_addr;
   logic [0:NP-1][0:31]       req_address;
   logic [0:NP-1][0:3]        req_write_en;
   logic [0:NP-1][0:31]       req_write_data;
   logic [0:NP-1][0:3]        req_read_en;
   logic                      mem_valid;
   logic                      mem_ready;
   logic [0:RW-1]             mem_rs_id;
   logic [0:4]                mem_result_reg_addr;
   logic [0:31]               mem_address;
   logic [0:3]                mem_write_en;
   logic [0:31]               mem_write_data;
   logic [0:3]                mem_read_en;
   logic                      mem_out_valid;
   logic                      mem_out_ready;
   logic [0:RW-1]             mem_out_rs_id;
   logic [0:4]                mem_out_result_reg_addr;
   logic [0:31]               mem_out_read_data;
   logic [0:NP-1]             resp_valid;
   logic [0:NP-1]             resp_ready;
   logic [0:RW-1]             resp_rs_id;
   logic [0:4]                resp_result_reg_addr;
   logic [0:31]               resp_read_data;
   logic                      err_unexpected_resp;

   data_mem_arbiter #(.NUM_PORTS(NP), .RS_ID_WIDTH(RW), .MAX_OUTSTANDING(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_rs_id(req_rs_id),
      .req_result_reg_addr(req_result_reg_addr), .req_address(req_address),
      .req_write_en(req_write_en), .req_write_data(req_write_data),
      .req_read_en(req_read_en),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rs_id(mem_rs_id),
      .mem_result_reg_addr(mem_result_reg_addr), .mem_address(mem_address),
      .mem_write_en(mem_write_en), .mem_write_data(mem_write_data),
      .mem_read_en(mem_read_en),
      .mem_out_valid(mem_out_valid), .mem_out_ready(mem_out_ready),
      .mem_out_rs_id(mem_out_rs_id), .mem_out_result_reg_addr(mem_out_result_reg_addr),
      .mem_out_read_data(mem_out_read_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rs_id(resp_rs_id),
      .resp_result_reg_addr(resp_result_reg_addr), .resp_read_data(resp_read_data),
      .err_unexpected_resp(err_unexpected_resp)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        v0, v1;
      logic [3:0]  re0, we0, re1, we1;
      logic [31:0] a0, a1;
      logic        mrdy, ov, rr0, rr1;
      logic        x_rdy0, x_rdy1, x_mv;
      logic [31:0] x_addr;
      logic        x_rv0, x_rv1, x_ordy;
   } vec_t;

   vec_t vecs[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_port(input int p, input logic v, input logic [3:0] re,
                             input logic [3:0] we, input logic [31:0] a);
      req_valid[p]    = v;
      req_read_en[p]  = re;
      req_write_en[p] = we;
      req_address[p]  = a;
   endtask

   initial begin
      // Column order: v0 v1 re0 we0 re1 we1 a0 a1 mrdy ov rr0 rr1 |
      //               x_rdy0 x_rdy1 x_mv x_addr x_rv0 x_rv1 x_ordy
      // Alternating reads from both ports, results returned in issue order
      vecs.push_back('{1,1,4'hF,4'h0,4'hF,4'h0,32'h100,32'h200,1,0,1,1, 1,0,1,32'h100,0,0,0});
      vecs.push_back('{1,1,4'hF,4'h0,4'hF,4'h0,32'h100,32'h200,1,0,1,1, 0,1,1,32'h200,0,0,1});
      vecs.push_back('{1,1,4'hF,4'h0,4'hF,4'h0,32'h100,32'h200,1,1,1,1, 1,0,1,32'h100,1,0,1});
      vecs.push_back('{1,1,4'hF,4'h0,4'hF,4'h0,32'h100,32'h200,1,1,1,1, 0,1,1,32'h200,0,1,1});
      vecs.push_back('{0,0,4'h0,4'h0,4'h0,4'h0,32'h100,32'h200,1,1,1,1, 0,0,0,32'h0,1,0,1});
      vecs.push_back('{0,0,4'h0,4'h0,4'h0,4'h0,32'h100,32'h200,1,1,1,1, 0,0,0,32'h0,0,1,1});
      vecs.push_back('{0,0,4'h0,4'h0,4'h0,4'h0,32'h100,32'h200,1,0,1,1, 0,0,0,32'h0,0,0,0});
      // Null request on port 0: accepted locally, not forwarded
      vecs.push_back('{1,0,4'h0,4'h0,4'h0,4'h0,32'h100,32'h200,1,0,1,1, 1,0,0,32'h0,0,0,0});
      // Misaligned store on port 1 stalled one cycle while port 0 waits
      vecs.push_back('{1,1,4'hF,4'h0,4'h0,4'hF,32'h100,32'h3,0,0,1,1, 0,0,1,32'h3,0,0,0});
      vecs.push_back('{1,1,4'hF,4'h0,4'h0,4'hF,32'h100,32'h3,1,0,1,1, 0,1,1,32'h3,0,0,0});
      vecs.push_back('{1,0,4'hF,4'h0,4'h0,4'h0,32'h100,32'h3,1,0,1,1, 1,0,1,32'h100,0,0,0});
      vecs.push_back('{0,0,4'h0,4'h0,4'h0,4'h0,32'h100,32'h3,1,1,1,1, 0,0,0,32'h0,1,0,1});
      vecs.push_back('{0,0,4'h0,4'h0,4'h0,4'h0,32'h100,32'h3,1,0,1,1, 0,0,0,32'h0,0,0,0});

      rst           = 1'b1;
      req_valid     = '0;
      req_read_en   = '0;
      req_write_en  = '0;
      req_address   = '0;
      req_rs_id[0]  = 5'd3;
      req_rs_id[1]  = 5'd9;
      req_result_reg_addr[0] = 5'd1;
      req_result_reg_addr[1] = 5'd2;
      req_write_data[0] = 32'h1111_0000;
      req_write_data[1] = 32'h2222_0000;
      mem_ready     = 1'b0;
      mem_out_valid = 1'b0;
      mem_out_rs_id = 5'd3;
      mem_out_result_reg_addr = 5'd1;
      mem_out_read_data = 32'h0;
      resp_ready    = '0;

      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset req_ready", 32'(req_ready), 32'h0);
      check("reset mem_valid", 32'(mem_valid), 32'h0);
      check("reset resp_valid", 32'(resp_valid), 32'h0);
      check("reset mem_out_ready", 32'(mem_out_ready), 32'h0);
      check("reset err", 32'(err_unexpected_resp), 32'h0);

      // Table-driven cycles
      for (int n = 0; n < vecs.size(); n++) begin
         @(negedge clk);
         drive_port(0, vecs[n].v0, vecs[n].re0, vecs[n].we0, vecs[n].a0);
         drive_port(1, vecs[n].v1, vecs[n].re1, vecs[n].we1, vecs[n].a1);
         mem_ready     = vecs[n].mrdy;
         mem_out_valid = vecs[n].ov;
         resp_ready[0] = vecs[n].rr0;
         resp_ready[1] = vecs[n].rr1;
         #1;
         check($sformatf("v%0d req_ready0", n), 32'(req_ready[0]), 32'(vecs[n].x_rdy0));
         check($sformatf("v%0d req_ready1", n), 32'(req_ready[1]), 32'(vecs[n].x_rdy1));
         check($sformatf("v%0d mem_valid", n), 32'(mem_valid), 32'(vecs[n].x_mv));
         if (vecs[n].x_mv)
            check($sformatf("v%0d mem_address", n), mem_address, vecs[n].x_addr);
         check($sformatf("v%0d resp_valid0", n), 32'(resp_valid[0]), 32'(vecs[n].x_rv0));
         check($sformatf("v%0d resp_valid1", n), 32'(resp_valid[1]), 32'(vecs[n].x_rv1));
         check($sformatf("v%0d mem_out_ready", n), 32'(mem_out_ready), 32'(vecs[n].x_ordy));
      end

      // Five reads from port 0 with results blocked: only four fit
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         drive_port(0, 1'b1, 4'hF, 4'h0, 32'h100);
         drive_port(1, 1'b0, 4'h0, 4'h0, 32'h0);
         mem_ready = 1'b1;
         mem_out_valid = 1'b0;
         resp_ready = '0;
         #1;
         check($sformatf("full read%0d req_ready0", i), 32'(req_ready[0]), (i < 4) ? 32'h1 : 32'h0);
         if (i == 4) check("full read4 mem_valid", 32'(mem_valid), 32'h0);
      end
      @(negedge clk);
      mem_out_valid = 1'b1;
      mem_out_read_data = 32'hA5A5_0000;
      resp_ready[0] = 1'b1;
      #1;
      check("full pop resp_valid0", 32'(resp_valid[0]), 32'h1);
      check("full pop mem_out_ready", 32'(mem_out_ready), 32'h1);
      check("full pop req_ready0", 32'(req_ready[0]), 32'h0);
      @(negedge clk);
      mem_out_valid = 1'b0;
      #1;
      check("full retry req_ready0", 32'(req_ready[0]), 32'h1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         req_valid = '0;
         mem_out_valid = 1'b1;
         mem_out_read_data = 32'hA5A5_0001 + 32'(i);
         #1;
         check($sformatf("drain%0d resp_valid0", i), 32'(resp_valid[0]), 32'h1);
         check($sformatf("drain%0d resp_read_data", i), resp_read_data, 32'hA5A5_0001 + 32'(i));
      end
      @(negedge clk);
      mem_out_valid = 1'b0;
      #1;
      check("drained mem_out_ready", 32'(mem_out_ready), 32'h0);

      // Result with nothing outstanding
      @(negedge clk);
      mem_out_valid = 1'b1;
      #1;
      check("unexp mem_out_ready", 32'(mem_out_ready), 32'h0);
      check("unexp resp_valid", 32'(resp_valid), 32'h0);
      check("unexp err before edge", 32'(err_unexpected_resp), 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         mem_out_valid = 1'b0;
         #1;
         check($sformatf("unexp err sticky%0d", i), 32'(err_unexpected_resp), 32'h1);
      end

      // Reset with two reads outstanding and a stalled store locked on port 1
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         drive_port(0, 1'b1, 4'hF, 4'h0, 32'h100);
         mem_ready = 1'b1;
         #1;
         check($sformatf("pre-rst read%0d req_ready0", i), 32'(req_ready[0]), 32'h1);
      end
      @(negedge clk);
      drive_port(1, 1'b1, 4'h0, 4'hF, 32'h3);
      mem_ready = 1'b0;
      #1;
      check("pre-rst lock mem_address", mem_address, 32'h3);
      check("pre-rst lock req_ready1", 32'(req_ready[1]), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      mem_out_valid = 1'b1;
      #1;
      check("in-rst req_ready", 32'(req_ready), 32'h0);
      check("in-rst mem_valid", 32'(mem_valid), 32'h0);
      check("in-rst resp_valid", 32'(resp_valid), 32'h0);
      check("in-rst mem_out_ready", 32'(mem_out_ready), 32'h0);
      @(negedge clk);
      #1;
      check("post-rst err", 32'(err_unexpected_resp), 32'h0);
      rst = 1'b0;
      mem_ready = 1'b1;
      mem_out_valid = 1'b0;
      #1;
      check("post-rst mem_out_ready", 32'(mem_out_ready), 32'h0);
      check("post-rst grant req_ready0", 32'(req_ready[0]), 32'h1);
      check("post-rst grant req_ready1", 32'(req_ready[1]), 32'h0);
      check("post-rst mem_address", mem_address, 32'h100);
      @(negedge clk);
      req_valid = '0;
      mem_out_valid = 1'b1;
      #1;
      check("post-rst resp_valid0", 32'(resp_valid[0]), 32'h1);
      check("post-rst resp mem_out_ready", 32'(mem_out_ready), 32'h1);
      @(negedge clk);
      mem_out_valid = 1'b0;
      #1;
      check("post-rst empty mem_out_ready", 32'(mem_out_ready), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
